phys_reg_free_arbiter: RTL and testbench

//   Merges the two sources of freed physical register tags into the single enqueue port of

---
 rtl/phys_reg_free_arbiter.sv | 88 ++++++++
 tb/tb_phys_reg_free_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_arbiter.sv
// Merges ROB-commit and revert frees into one free-list enqueue port via a small FIFO.
// Ports: CLK/RST, commit/revert free handshakes, rename gating, prfl_* free-list side, drain/err status.
module phys_reg_free_arbiter #(
  parameter int TAG_W     = 6,
  parameter int BUF_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           commit_free_valid,
  input  logic [TAG_W-1:0]               commit_free_tag,
  output logic                           commit_free_ready,
  input  logic                           revert_free_valid,
  input  logic [TAG_W-1:0]               revert_free_tag,
  output logic                           revert_free_ready,
  input  logic                           rename_req_valid,
  output logic                           rename_grant,
  input  logic                           prfl_empty,
  input  logic                           prfl_full,
  output logic                           prfl_dequeue_valid,
  output logic                           prfl_enqueue_valid,
  output logic [TAG_W-1:0]               prfl_enqueue_phys_reg_tag,
  output logic [$clog2(BUF_DEPTH):0]     buf_count,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic                           err_overflow
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    space;
  logic             rev_acc;
  logic             com_acc;
  logic             pop;
  logic             unused;

  assign space = CW'(BUF_DEPTH) - count;

  // Revert wins the last free slot.
  assign revert_free_ready = (space >= CW'(1));
  assign commit_free_ready = (space >= CW'(2)) |
                             ((space == CW'(1)) & ~revert_free_valid);

  assign rev_acc = revert_free_valid & revert_free_ready;
  assign com_acc = commit_free_valid & commit_free_ready;

  assign pop = (count != '0) & ~prfl_full;

  assign prfl_enqueue_valid        = pop;
  assign prfl_enqueue_phys_reg_tag = mem[head];
  assign buf_count                 = count;

  assign rename_grant       = rename_req_valid & ~prfl_empty;
  assign prfl_dequeue_valid = rename_grant;

  // drain_req only qualifies the handshake on the restore side.
  assign drain_done = (count == '0) & ~commit_free_valid & ~revert_free_valid;
  assign unused     = drain_req;

  // Storage is not reset; head/tail/count define what is valid.
  always_ff @(posedge CLK) begin
    if (rev_acc)
      mem[tail] <= revert_free_tag;
    if (com_acc)
      mem[tail + PW'(rev_acc)] <= commit_free_tag;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
    end else begin
      tail  <= tail + PW'(rev_acc) + PW'(com_acc);
      head  <= head + PW'(pop);
      count <= count + CW'(rev_acc) + CW'(com_acc) - CW'(pop);
      // Frees backing up against a full list means a double free somewhere.
      if (prfl_full && (count != '0))
        err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_arbiter.sv
// Directed bench for phys_reg_free_arbiter with a queue-based reference model.
// Checks every cycle against the model plus hand-computed literal points.
module tb_phys_reg_free_arbiter;

  localparam int TAG_W = 6;
  localparam int DEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             commit_free_valid;
  logic [TAG_W-1:0] commit_free_tag;
  logic             commit_free_ready;
  logic             revert_free_valid;
  logic [TAG_W-1:0] revert_free_tag;
  logic             revert_free_ready;
  logic             rename_req_valid;
  logic             rename_grant;
  logic             prfl_empty;
  logic             prfl_full;
  logic             prfl_dequeue_valid;
  logic             prfl_enqueue_valid;
  logic [TAG_W-1:0] prfl_enqueue_phys_reg_tag;
  logic [2:0]       buf_count;
  logic             drain_req;
  logic             drain_done;
  logic             err_overflow;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  phys_reg_free_arbiter #(.TAG_W(TAG_W), .BUF_DEPTH(DEPTH)) dut (
    .CLK                       (CLK),
    .RST                       (RST),
    .commit_free_valid         (commit_free_valid),
    .commit_free_tag           (commit_free_tag),
    .commit_free_ready         (commit_free_ready),
    .revert_free_valid         (revert_free_valid),
    .revert_free_tag           (revert_free_tag),
    .revert_free_ready         (revert_free_ready),
    .rename_req_valid          (rename_req_valid),
    .rename_grant              (rename_grant),
    .prfl_empty                (prfl_empty),
    .prfl_full                 (prfl_full),
    .prfl_dequeue_valid        (prfl_dequeue_valid),
    .prfl_enqueue_valid        (prfl_enqueue_valid),
    .prfl_enqueue_phys_reg_tag (prfl_enqueue_phys_reg_tag),
    .buf_count                 (buf_count),
    .drain_req                 (drain_req),
    .drain_done                (drain_done),
    .err_overflow              (err_overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of tags and a sticky error flag.
  logic [TAG_W-1:0] q[$];
  bit               m_err = 0;
  bit               started = 0;

  function automatic int m_space();
    return DEPTH - q.size();
  endfunction

  function automatic bit m_rrdy();
    return m_space() >= 1;
  endfunction

  function automatic bit m_crdy(input bit rv);
    return (m_space() >= 2) || (m_space() == 1 && !rv);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      q.delete();
      m_err   = 0;
      started = 1;
    end else if (started) begin
      bit rv_ok;
      bit cv_ok;
      bit pop;
      rv_ok = revert_free_valid && m_rrdy();
      cv_ok = commit_free_valid && m_crdy(revert_free_valid);
      pop   = (q.size() != 0) && !prfl_full;
      if (prfl_full && q.size() != 0)
        m_err = 1;
      if (pop)
        void'(q.pop_front());
      if (rv_ok)
        q.push_back(revert_free_tag);
      if (cv_ok)
        q.push_back(commit_free_tag);
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      bit ev;
      ev = (q.size() != 0) && !prfl_full;
      chk("m_count", 32'(buf_count), 32'(q.size()));
      chk("m_cnt_max", 32'(buf_count <= 3'd4), 32'd1);
      chk("m_enq_v", 32'(prfl_enqueue_valid), 32'(ev));
      if (ev)
        chk("m_enq_tag", 32'(prfl_enqueue_phys_reg_tag), 32'(q[0]));
      chk("m_rrdy", 32'(revert_free_ready), 32'(m_rrdy()));
      chk("m_crdy", 32'(commit_free_ready),
          32'(m_crdy(revert_free_valid)));
      chk("m_grant", 32'(rename_grant),
          32'(rename_req_valid && !prfl_empty));
      chk("m_deq", 32'(prfl_dequeue_valid),
          32'(rename_req_valid && !prfl_empty));
      chk("m_drain", 32'(drain_done),
          32'(q.size() == 0 && !commit_free_valid && !revert_free_valid));
      chk("m_err", 32'(err_overflow), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic drain_wait(input string nm);
    int n = 0;
    while (buf_count != 3'd0 && n < 10) begin
      step();
      n++;
    end
    chk(nm, 32'(buf_count), 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    commit_free_valid = 1'b0;
    commit_free_tag   = '0;
    revert_free_valid = 1'b0;
    revert_free_tag   = '0;
    rename_req_valid  = 1'b0;
    prfl_empty        = 1'b0;
    prfl_full         = 1'b0;
    drain_req         = 1'b0;

    // 1 reset
    step();
    step();
    RST = 1'b0;
    at_neg();
    chk("rst_count", 32'(buf_count), 32'd0);
    chk("rst_enq", 32'(prfl_enqueue_valid), 32'd0);
    chk("rst_err", 32'(err_overflow), 32'd0);
    chk("rst_rrdy", 32'(revert_free_ready), 32'd1);
    chk("rst_crdy", 32'(commit_free_ready), 32'd1);

    // 2 single commit free
    step();
    commit_free_valid = 1'b1;
    commit_free_tag   = 6'h21;
    step();
    commit_free_valid = 1'b0;
    at_neg();
    chk("t2_enq_v", 32'(prfl_enqueue_valid), 32'd1);
    chk("t2_tag", 32'(prfl_enqueue_phys_reg_tag), 32'h21);
    step();
    at_neg();
    chk("t2_count", 32'(buf_count), 32'd0);

    // 3 simultaneous frees for 3 cycles
    step();
    revert_free_valid = 1'b1;
    revert_free_tag   = 6'h05;
    commit_free_valid = 1'b1;
    commit_free_tag   = 6'h3A;
    at_neg();
    chk("t3_c0_crdy", 32'(commit_free_ready), 32'd1);
    step();
    at_neg();
    chk("t3_c1_count", 32'(buf_count), 32'd2);
    chk("t3_c1_tag", 32'(prfl_enqueue_phys_reg_tag), 32'h05);
    step();
    at_neg();
    chk("t3_c2_count", 32'(buf_count), 32'd3);
    chk("t3_c2_crdy", 32'(commit_free_ready), 32'd0);
    chk("t3_c2_rrdy", 32'(revert_free_ready), 32'd1);
    chk("t3_c2_tag", 32'(prfl_enqueue_phys_reg_tag), 32'h3A);
    step();
    revert_free_valid = 1'b0;
    commit_free_valid = 1'b0;
    drain_wait("t3_drain");

    // 4 fill while full, then release
    prfl_full         = 1'b1;
    revert_free_valid = 1'b1;
    revert_free_tag   = 6'h11;
    commit_free_valid = 1'b1;
    commit_free_tag   = 6'h12;
    step();
    revert_free_tag = 6'h13;
    commit_free_tag = 6'h14;
    step();
    revert_free_valid = 1'b0;
    commit_free_valid = 1'b0;
    at_neg();
    chk("t4_count", 32'(buf_count), 32'd4);
    chk("t4_enq", 32'(prfl_enqueue_valid), 32'd0);
    chk("t4_rrdy", 32'(revert_free_ready), 32'd0);
    chk("t4_crdy", 32'(commit_free_ready), 32'd0);
    chk("t4_err", 32'(err_overflow), 32'd1);
    step();
    prfl_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_tag;
      exp_tag = 32'h11 + 32'(i);
      at_neg();
      chk("t4_pop_v", 32'(prfl_enqueue_valid), 32'd1);
      chk("t4_pop_tag", 32'(prfl_enqueue_phys_reg_tag), exp_tag);
      step();
    end
    at_neg();
    chk("t4_empty", 32'(buf_count), 32'd0);
    chk("t4_err_hold", 32'(err_overflow), 32'd1);

    // 5 rename gating
    step();
    commit_free_valid = 1'b1;
    commit_free_tag   = 6'h2F;
    step();
    commit_free_valid = 1'b0;
    rename_req_valid  = 1'b1;
    prfl_empty        = 1'b1;
    at_neg();
    chk("t5_count", 32'(buf_count), 32'd1);
    chk("t5_nogrant", 32'(rename_grant), 32'd0);
    step();
    prfl_empty = 1'b0;
    at_neg();
    chk("t5_grant", 32'(rename_grant), 32'd1);
    chk("t5_deq", 32'(prfl_dequeue_valid), 32'd1);
    step();
    rename_req_valid = 1'b0;

    // 6 reset mid-stream, then drain handshake
    prfl_full         = 1'b1;
    revert_free_valid = 1'b1;
    revert_free_tag   = 6'h0A;
    commit_free_valid = 1'b1;
    commit_free_tag   = 6'h0B;
    step();
    revert_free_valid = 1'b0;
    commit_free_tag   = 6'h0C;
    at_neg();
    chk("t6_nodrain", 32'(drain_done), 32'd0);
    step();
    commit_free_valid = 1'b0;
    at_neg();
    chk("t6_count3", 32'(buf_count), 32'd3);
    RST = 1'b1;
    step();
    RST       = 1'b0;
    prfl_full = 1'b0;
    at_neg();
    chk("t6_rst_count", 32'(buf_count), 32'd0);
    chk("t6_rst_enq", 32'(prfl_enqueue_valid), 32'd0);
    chk("t6_rst_err", 32'(err_overflow), 32'd0);
    step();
    drain_req = 1'b1;
    at_neg();
    chk("t6_drain", 32'(drain_done), 32'd1);
    step();
    drain_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
